// File: rtl/dual_bus_system_top.sv
// dual_bus_system_top: one external master on bus A. Bus A serves two local
// 4 KB memories (A0, A1) and a bridge to bus B, which serves one 4 KB memory (B0).
// One transfer at a time; mready low while a transfer is in flight.
module dual_bus_system_top #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] maddr,
    input  logic [DATA_W-1:0] mwdata,
    input  logic              wen,
    input  logic              mwvalid,
    output logic              mready,
    output logic [DATA_W-1:0] mrdata,
    output logic              merr
);

    localparam int PAGE_W    = ADDR_W - MEM_AW;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        RESP_A = 3'd2,
        REQ_B  = 3'd3,
        RESP_B = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              mready_q, mready_d;
    logic              merr_q, merr_d;
    logic [DATA_W-1:0] mrdata_q, mrdata_d;

    // Latched copy of the accepted request; the master may change its inputs afterwards
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;

    // Bus-local read-return registers
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic [DATA_W-1:0] mem_a0 [MEM_DEPTH];
    logic [DATA_W-1:0] mem_a1 [MEM_DEPTH];
    logic [DATA_W-1:0] mem_b0 [MEM_DEPTH];

    logic [PAGE_W-1:0] page;
    logic [MEM_AW-1:0] offset;
    logic              sel_a0, sel_a1, sel_br, mapped;
    logic [DATA_W-1:0] a_local_rd;
    logic              wr_a0, wr_a1, wr_b0;

    assign page   = addr_q[ADDR_W-1:MEM_AW];
    assign offset = addr_q[MEM_AW-1:0];
    assign sel_a0 = (page == PAGE_W'(0));
    assign sel_a1 = (page == PAGE_W'(1));
    assign sel_br = (page == PAGE_W'(2));
    assign mapped = sel_a0 | sel_a1 | sel_br;

    // Unmapped reads fall through to zero on bus A
    assign a_local_rd = sel_a0 ? mem_a0[offset] :
                        sel_a1 ? mem_a1[offset] : '0;

    // Commits happen on the edge leaving the request state; reset on that edge cancels them
    assign wr_a0 = (state_q == REQ_A) && wen_q && sel_a0 && !rst;
    assign wr_a1 = (state_q == REQ_A) && wen_q && sel_a1 && !rst;
    assign wr_b0 = (state_q == REQ_B) && wen_q && !rst;

    // Next-state and output computation for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        mready_d  = mready_q;
        merr_d    = merr_q;
        mrdata_d  = mrdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        case (state_q)
            IDLE: begin
                if (mwvalid && mready_q) begin
                    addr_d   = maddr;
                    wdata_d  = mwdata;
                    wen_d    = wen;
                    merr_d   = 1'b0;
                    mready_d = 1'b0;
                    state_d  = REQ_A;
                end
            end
            REQ_A: begin
                if (sel_br) begin
                    state_d = REQ_B;
                end else begin
                    state_d = RESP_A;
                    if (!wen_q) rdata_a_d = a_local_rd;
                end
            end
            REQ_B: begin
                state_d = RESP_B;
                if (!wen_q) rdata_b_d = mem_b0[offset];
            end
            RESP_B: begin
                state_d = RESP_A;
                if (!wen_q) rdata_a_d = rdata_b_q;
            end
            RESP_A: begin
                state_d  = IDLE;
                mready_d = 1'b1;
                merr_d   = !mapped;
                if (!wen_q) mrdata_d = rdata_a_q;
            end
            default: begin
                state_d  = IDLE;
                mready_d = 1'b1;
            end
        endcase
    end

    // Control and master-visible outputs, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mready_q <= 1'b1;
            merr_q   <= 1'b0;
            mrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            mready_q <= mready_d;
            merr_q   <= merr_d;
            mrdata_q <= mrdata_d;
        end
    end

    // Request copy and bus-local data registers; only meaningful once the sequencer uses them
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        wen_q     <= wen_d;
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
    end

    // Slave memories; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_a0) mem_a0[offset] <= wdata_q;
        if (wr_a1) mem_a1[offset] <= wdata_q;
        if (wr_b0) mem_b0[offset] <= wdata_q;
    end

    assign mready = mready_q;
    assign mrdata = mrdata_q;
    assign merr   = merr_q;

endmodule

// File: tb/tb_dual_bus_system_top.sv
// Directed bench for dual_bus_system_top: local, bridged and unmapped transfers,
// ignored requests while busy, and reset during a bridge write.
module tb_dual_bus_system_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] maddr;
    logic [7:0]  mwdata;
    logic        wen;
    logic        mwvalid;
    logic        mready;
    logic [7:0]  mrdata;
    logic        merr;

    int checks = 0;
    int errors = 0;

    dual_bus_system_top #(.ADDR_W(16), .DATA_W(8), .MEM_AW(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .maddr  (maddr),
        .mwdata (mwdata),
        .wen    (wen),
        .mwvalid(mwvalid),
        .mready (mready),
        .mrdata (mrdata),
        .merr   (merr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle, then scramble the inputs
    task automatic start(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(negedge clk);
        maddr   = a;
        mwdata  = d;
        wen     = w;
        mwvalid = 1'b1;
        @(posedge clk);
        #1;
        mwvalid = 1'b0;
        maddr   = 16'hFFFF;
        mwdata  = 8'h99;
        wen     = ~w;
    endtask

    // Full transfer; checks how many cycles mready stayed low
    task automatic xfer(input string tag, input logic [15:0] a, input logic [7:0] d,
                        input logic w, input int exp_low);
        int n;
        start(a, d, w);
        n = 0;
        while (mready !== 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_low"}, n, exp_low);
    endtask

    initial begin
        rst     = 1'b1;
        maddr   = '0;
        mwdata  = '0;
        wen     = 1'b0;
        mwvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mready", mready, 1'b1);
        chk("rst_mrdata", mrdata, 8'h00);
        chk("rst_merr", merr, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Local writes and reads on A0
        xfer("wr_0abc", 16'h0ABC, 8'h55, 1'b1, 2);
        chk("wr_0abc_merr", merr, 1'b0);
        xfer("wr_02c5", 16'h02C5, 8'h34, 1'b1, 2);
        chk("wr_02c5_merr", merr, 1'b0);
        chk("wr_keeps_mrdata", mrdata, 8'h00);
        xfer("rd_0abc", 16'h0ABC, 8'h00, 1'b0, 2);
        chk("rd_0abc_data", mrdata, 8'h55);
        xfer("rd_02c5", 16'h02C5, 8'h00, 1'b0, 2);
        chk("rd_02c5_data", mrdata, 8'h34);

        // A1 is independent of A0 at the same offset
        xfer("wr_1abc", 16'h1ABC, 8'h66, 1'b1, 2);
        xfer("rd_1abc", 16'h1ABC, 8'h00, 1'b0, 2);
        chk("rd_1abc_data", mrdata, 8'h66);
        xfer("rd_0abc_b", 16'h0ABC, 8'h00, 1'b0, 2);
        chk("rd_0abc_again", mrdata, 8'h55);

        // Bridge to B0; A0 offset 0x010 and 0x000 are seeded first
        xfer("wr_0010", 16'h0010, 8'h5A, 1'b1, 2);
        xfer("wr_0000", 16'h0000, 8'h77, 1'b1, 2);
        xfer("wr_2010", 16'h2010, 8'hA5, 1'b1, 4);
        chk("wr_2010_merr", merr, 1'b0);
        chk("wr_2010_mrdata", mrdata, 8'h55);
        xfer("rd_2010", 16'h2010, 8'h00, 1'b0, 4);
        chk("rd_2010_data", mrdata, 8'hA5);
        chk("rd_2010_merr", merr, 1'b0);
        xfer("rd_0010", 16'h0010, 8'h00, 1'b0, 2);
        chk("rd_0010_data", mrdata, 8'h5A);

        // Unmapped page
        xfer("wr_7000", 16'h7000, 8'hFF, 1'b1, 2);
        chk("wr_7000_merr", merr, 1'b1);
        chk("wr_7000_mrdata", mrdata, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        chk("merr_held", merr, 1'b1);
        xfer("rd_7000", 16'h7000, 8'h00, 1'b0, 2);
        chk("rd_7000_merr", merr, 1'b1);
        chk("rd_7000_data", mrdata, 8'h00);
        xfer("rd_0000", 16'h0000, 8'h00, 1'b0, 2);
        chk("rd_0000_data", mrdata, 8'h77);
        chk("rd_0000_merr", merr, 1'b0);
        xfer("rd_2000", 16'h2000, 8'h00, 1'b0, 4);
        xfer("wr_2000", 16'h2000, 8'h3B, 1'b1, 4);
        xfer("rd_2000_b", 16'h2000, 8'h00, 1'b0, 4);
        chk("rd_2000_data", mrdata, 8'h3B);

        // Request pulsed while busy is ignored
        xfer("wr_0101", 16'h0101, 8'h00, 1'b1, 2);
        start(16'h0100, 8'h11, 1'b1);
        chk("busy_mready", mready, 1'b0);
        maddr   = 16'h0101;
        mwdata  = 8'h22;
        wen     = 1'b1;
        mwvalid = 1'b1;
        @(posedge clk);
        #1;
        mwvalid = 1'b0;
        chk("busy_still_low", mready, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_done", mready, 1'b1);
        @(posedge clk);
        #1;
        chk("no_queued_xfer", mready, 1'b1);
        xfer("rd_0101", 16'h0101, 8'h00, 1'b0, 2);
        chk("rd_0101_data", mrdata, 8'h00);
        xfer("rd_0100", 16'h0100, 8'h00, 1'b0, 2);
        chk("rd_0100_data", mrdata, 8'h11);

        // Reset during a bridge write, in REQ_A
        xfer("wr_2020", 16'h2020, 8'hC3, 1'b1, 4);
        start(16'h2020, 8'h3C, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_mready", mready, 1'b1);
        chk("rst_mid_mrdata", mrdata, 8'h00);
        chk("rst_mid_merr", merr, 1'b0);
        rst = 1'b0;
        xfer("rd_2020", 16'h2020, 8'h00, 1'b0, 4);
        chk("rd_2020_data", mrdata, 8'hC3);

        // Reset during a bridge write, in REQ_B
        xfer("wr_2030", 16'h2030, 8'h11, 1'b1, 4);
        start(16'h2030, 8'hEE, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_reqb_mready", mready, 1'b1);
        rst = 1'b0;
        xfer("rd_2030", 16'h2030, 8'h00, 1'b0, 4);
        chk("rd_2030_data", mrdata, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
